// File: rtl/perf_uart_reporter.sv
// perf_uart_reporter: on a halt_flag rising edge or a report_req, snapshots the CPU
// status counters and sends them as a frame of UART 8N1 bytes on tx.
// Frame: SYNC_BYTE, cycle_count, instr_count, current_pc (each LSB byte first),
// flags {7'b0, halt}.
// Optional feature macro: CHECKSUM_EN appends the XOR of every byte after SYNC_BYTE.
module perf_uart_reporter #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cycle_count,
    input  logic [31:0] instr_count,
    input  logic [31:0] current_pc,
    input  logic        halt_flag,
    input  logic        report_req,
    output logic        tx,
    output logic        busy,
    output logic        done
);

`ifdef CHECKSUM_EN
    localparam int NBYTES = 15;
`else
    localparam int NBYTES = 14;
`endif

    localparam int             BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]     BYTE_LAST = 4'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t         state_q, state_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [2:0]     bit_q, bit_d;
    logic [3:0]     byte_q, byte_d;
    logic           done_q, done_d;
    logic           halt_q;
    logic [31:0]    cyc_q, ins_q, pc_q;
    logic           flag_q;

    logic           trigger;
    logic           bit_end;
    logic           snap;
    logic [7:0]     cur_byte;

    assign trigger = report_req | (halt_flag & ~halt_q);
    assign bit_end = (baud_q == BAUD_LAST);

`ifdef CHECKSUM_EN
    logic [7:0] csum;
    assign csum = cyc_q[7:0] ^ cyc_q[15:8] ^ cyc_q[23:16] ^ cyc_q[31:24]
                ^ ins_q[7:0] ^ ins_q[15:8] ^ ins_q[23:16] ^ ins_q[31:24]
                ^ pc_q[7:0]  ^ pc_q[15:8]  ^ pc_q[23:16]  ^ pc_q[31:24]
                ^ {7'b0, flag_q};
`endif

    // State, counters, halt edge detector and the frame snapshot
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            done_q  <= 1'b0;
            halt_q  <= 1'b0;
            cyc_q   <= '0;
            ins_q   <= '0;
            pc_q    <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            done_q  <= done_d;
            halt_q  <= halt_flag;
            if (snap) begin
                cyc_q  <= cycle_count;
                ins_q  <= instr_count;
                pc_q   <= current_pc;
                flag_q <= halt_flag;
            end
        end
    end

    // Next-state logic: bit timing, bit/byte sequencing and snapshot strobe
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        done_d  = 1'b0;
        snap    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    state_d = S_START;
                    baud_d  = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                    snap    = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (byte_q == BYTE_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_START;
                        byte_d  = byte_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Byte selector: picks the frame byte addressed by byte_q from the snapshot
    always_comb begin
        cur_byte = 8'h00;
        case (byte_q)
            4'd0:  cur_byte = SYNC_BYTE;
            4'd1:  cur_byte = cyc_q[7:0];
            4'd2:  cur_byte = cyc_q[15:8];
            4'd3:  cur_byte = cyc_q[23:16];
            4'd4:  cur_byte = cyc_q[31:24];
            4'd5:  cur_byte = ins_q[7:0];
            4'd6:  cur_byte = ins_q[15:8];
            4'd7:  cur_byte = ins_q[23:16];
            4'd8:  cur_byte = ins_q[31:24];
            4'd9:  cur_byte = pc_q[7:0];
            4'd10: cur_byte = pc_q[15:8];
            4'd11: cur_byte = pc_q[23:16];
            4'd12: cur_byte = pc_q[31:24];
            4'd13: cur_byte = {7'b0, flag_q};
`ifdef CHECKSUM_EN
            4'd14: cur_byte = csum;
`endif
            default: cur_byte = 8'h00;
        endcase
    end

    // Output decode: line level per state, busy while framing, registered done pulse
    always_comb begin
        tx   = 1'b1;
        busy = (state_q != S_IDLE);
        done = done_q;
        case (state_q)
            S_START: tx = 1'b0;
            S_DATA:  tx = cur_byte[bit_q];
            S_STOP:  tx = 1'b1;
            default: tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_perf_uart_reporter.sv
// Directed bench for perf_uart_reporter with CLKS_PER_BIT=4 (40 cycles per byte).
// Every frame cycle's tx level is compared with the waveform expected from the bytes.
module tb_perf_uart_reporter;

    localparam int CPB = 4;
`ifdef CHECKSUM_EN
    localparam int NB = 15;
`else
    localparam int NB = 14;
`endif

    typedef logic [7:0] frame_t [15];

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;
    logic [31:0] current_pc;
    logic        halt_flag;
    logic        report_req;
    logic        tx;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    perf_uart_reporter #(
        .CLKS_PER_BIT (CPB),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cycle_count (cycle_count),
        .instr_count (instr_count),
        .current_pc  (current_pc),
        .halt_flag   (halt_flag),
        .report_req  (report_req),
        .tx          (tx),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic frame_t model(input logic [31:0] cyc, input logic [31:0] ins,
                                     input logic [31:0] pc, input logic h);
        frame_t f;
        f[0] = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            f[1 + i] = cyc[8*i +: 8];
            f[5 + i] = ins[8*i +: 8];
            f[9 + i] = pc[8*i +: 8];
        end
        f[13] = {7'b0, h};
        f[14] = 8'h00;
        for (int i = 1; i < 14; i++) f[14] = f[14] ^ f[i];
        return f;
    endfunction

    function automatic logic exp_bit(input frame_t f, input int c);
        int b, by, p;
        b  = c / CPB;
        by = b / 10;
        p  = b % 10;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return f[by][p - 1];
    endfunction

    // Called at the negedge inside the first cycle of a frame.
    task automatic check_frame(input string tag, input frame_t f, input bit churn);
        int first_bad = -1;
        int busy_bad  = -1;
        for (int c = 0; c < NB * 10 * CPB; c++) begin
            if (tx !== exp_bit(f, c) && first_bad < 0) first_bad = c;
            if ((busy !== 1'b1 || done !== 1'b0) && busy_bad < 0) busy_bad = c;
            if (churn) begin
                cycle_count = cycle_count + 32'd1;
                if (c == 100) report_req = 1'b1;
                else if (c == 101) report_req = 1'b0;
            end
            @(negedge clk);
        end
        chk_int({tag, "_wave_first_bad_cycle"}, first_bad, -1);
        chk_int({tag, "_busy_first_bad_cycle"}, busy_bad, -1);
        chk_bit({tag, "_end_busy"}, busy, 1'b0);
        chk_bit({tag, "_end_done"}, done, 1'b1);
        chk_bit({tag, "_end_tx"}, tx, 1'b1);
        @(negedge clk);
        chk_bit({tag, "_done_clear"}, done, 1'b0);
    endtask

    task automatic pulse_req();
        report_req = 1'b1;
        @(negedge clk);
        report_req = 1'b0;
    endtask

    initial begin
        frame_t t2;
        frame_t f;
        int cnt_busy;
        int cnt_low;
        int cnt_done;

        rst = 1'b1;
        cycle_count = '0;
        instr_count = '0;
        current_pc  = '0;
        halt_flag   = 1'b0;
        report_req  = 1'b0;

        // 1: reset and idle
        repeat (3) @(negedge clk);
        chk_bit("rst_tx", tx, 1'b1);
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_done", done, 1'b0);
        rst = 1'b0;
        cnt_low = 0;
        cnt_busy = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1) cnt_low++;
            if (busy !== 1'b0) cnt_busy++;
        end
        chk_int("idle_tx_low_cycles", cnt_low, 0);
        chk_int("idle_busy_cycles", cnt_busy, 0);

        // 2: report_req frame
        cycle_count = 32'h32;
        instr_count = 32'h19;
        current_pc  = 32'h40;
        halt_flag   = 1'b0;
        t2 = '{8'hA5, 8'h32, 8'h00, 8'h00, 8'h00, 8'h19, 8'h00, 8'h00,
               8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h6B};
        @(negedge clk);
        pulse_req();
        chk_bit("t2_first_busy", busy, 1'b1);
        chk_bit("t2_start_bit", tx, 1'b0);
        check_frame("t2", t2, 1'b0);

        // 3: halt rising edge, then held high
        current_pc = 32'h5C;
        halt_flag  = 1'b1;
        @(negedge clk);
        check_frame("t3", model(32'h32, 32'h19, 32'h5C, 1'b1), 1'b0);
        cnt_busy = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy !== 1'b0) cnt_busy++;
        end
        chk_int("t3_no_second_frame", cnt_busy, 0);

        // 4: inputs change during frame and a mid-frame request is ignored
        cycle_count = 32'h0000_0100;
        instr_count = 32'h0000_0077;
        current_pc  = 32'h0000_1234;
        f = model(32'h0000_0100, 32'h0000_0077, 32'h0000_1234, 1'b1);
        pulse_req();
        check_frame("t4", f, 1'b1);
        cnt_busy = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy !== 1'b0) cnt_busy++;
        end
        chk_int("t4_no_queued_frame", cnt_busy, 0);

        // 5: reset during byte 3, then a clean frame
        cycle_count = 32'hDEAD_BEEF;
        instr_count = 32'h0102_0304;
        current_pc  = 32'h8000_0010;
        pulse_req();
        repeat (130) @(negedge clk);
        chk_bit("t5_busy_before_rst", busy, 1'b1);
        halt_flag = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk_bit("t5_rst_tx", tx, 1'b1);
        chk_bit("t5_rst_busy", busy, 1'b0);
        chk_bit("t5_rst_done", done, 1'b0);
        rst = 1'b0;
        cnt_done = 0;
        cnt_busy = 0;
        repeat (60) begin
            @(negedge clk);
            if (done !== 1'b0) cnt_done++;
            if (busy !== 1'b0) cnt_busy++;
        end
        chk_int("t5_no_done_after_rst", cnt_done, 0);
        chk_int("t5_no_busy_after_rst", cnt_busy, 0);
        pulse_req();
        check_frame("t5", model(32'hDEAD_BEEF, 32'h0102_0304, 32'h8000_0010, 1'b0), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
